tile_renderer: RTL and testbench

TILE_RENDERER -- requirements
Module: tile_renderer

---
 rtl/tile_renderer.sv | 130 +++++++++++++
 tb/tb_tile_renderer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// Tile-map VGA renderer: counters -> map RAM -> tile RAM -> palette; pixel (h,v) reaches o_rgb 5 cycles after the counters show it.
// Free-running pixel pipeline with no backpressure; the RAMs are expected to return data one cycle after each address.
module tile_renderer #(
  parameter int H_VISIBLE    = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_VISIBLE    = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int MAP_COLS     = 80
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [12:0] o_map_addr,
  input  logic [2:0]  i_map_data,
  output logic [8:0]  o_tile_addr,
  input  logic        i_tile_data,
  output logic [11:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_frame_tick
);

  localparam logic [9:0]  HV   = 10'(H_VISIBLE);
  localparam logic [9:0]  HL   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  HSS  = 10'(H_SYNC_START);
  localparam logic [9:0]  HSE  = 10'(H_SYNC_END);
  localparam logic [9:0]  VV   = 10'(V_VISIBLE);
  localparam logic [9:0]  VL   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VSS  = 10'(V_SYNC_START);
  localparam logic [9:0]  VSE  = 10'(V_SYNC_END);
  localparam logic [12:0] COLS = 13'(MAP_COLS);

  // Per-pixel sideband that travels down the pipeline with the addresses.
  typedef struct packed {
    logic [2:0] hl;
    logic [2:0] vl;
    logic       vis;
    logic       hs;
    logic       vs;
  } side_t;

  localparam side_t SIDE_RST = '{hl: 3'd0, vl: 3'd0, vis: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [9:0]  h, v;
  logic        visible;
  side_t       s0_side, s1_side, s2_side, s3_side, s4_side;
  logic [12:0] map_next;
  logic        blank_next;
  logic [8:0]  tile_next;
  logic [2:0]  s3_code, s4_code;
  logic        s3_blank, s4_blank;
  logic [11:0] pal_dat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (h == HL) begin
      h <= 10'd0;
      v <= (v == VL) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  assign visible      = (h < HV) && (v < VV);
  assign o_frame_tick = (h == 10'd0) && (v == VV);

  always_comb begin
    s0_side     = SIDE_RST;
    s0_side.hl  = h[2:0];
    s0_side.vl  = v[2:0];
    s0_side.vis = visible;
    s0_side.hs  = !((h >= HSS) && (h < HSE));
    s0_side.vs  = !((v >= VSS) && (v < VSE));
  end

  // Full 13-bit product: row 59 * 80 + col 79 = 4799 fits without truncation.
  assign map_next = visible ? ({6'd0, v[9:3]} * COLS + {6'd0, h[9:3]}) : 13'd0;

  // Codes 6 and 7 have no bitmap; park the tile address at 0 and blank the pixel.
  assign blank_next = i_map_data[2] & i_map_data[1];
  assign tile_next  = blank_next ? 9'd0 : {i_map_data, s2_side.vl, s2_side.hl};

  always_comb begin
    pal_dat = 12'h000;
    case (s4_code)
      3'd1, 3'd2, 3'd3: pal_dat = 12'h0F0;
      3'd4:             pal_dat = 12'hFFF;
      3'd5:             pal_dat = 12'hF00;
      default:          pal_dat = 12'h000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_map_addr  <= 13'd0;
      s1_side     <= SIDE_RST;
      s2_side     <= SIDE_RST;
      o_tile_addr <= 9'd0;
      s3_code     <= 3'd0;
      s3_blank    <= 1'b0;
      s3_side     <= SIDE_RST;
      s4_code     <= 3'd0;
      s4_blank    <= 1'b0;
      s4_side     <= SIDE_RST;
      o_rgb       <= 12'h000;
      o_hsync     <= 1'b1;
      o_vsync     <= 1'b1;
    end else begin
      o_map_addr  <= map_next;
      s1_side     <= s0_side;
      s2_side     <= s1_side;
      o_tile_addr <= tile_next;
      s3_code     <= i_map_data;
      s3_blank    <= blank_next;
      s3_side     <= s2_side;
      s4_code     <= s3_code;
      s4_blank    <= s3_blank;
      s4_side     <= s3_side;
      o_rgb       <= (s4_side.vis && i_tile_data && !s4_blank) ? pal_dat : 12'h000;
      o_hsync     <= s4_side.hs;
      o_vsync     <= s4_side.vs;
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: RAM models plus a pixel-index reference model; vertical timing shortened so frames fit the run.
module tb_tile_renderer;
  localparam int HV = 640, HT = 800, HSS = 656, HSE = 752;
  localparam int VV = 24, VT = 28, VSS = 25, VSE = 27;
  localparam int COLS = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] map_addr;
  logic [2:0]  map_data;
  logic [8:0]  tile_addr;
  logic        tile_data;
  logic [11:0] rgb;
  logic        hsync, vsync, frame_tick;

  always #5 clk = ~clk;

  tile_renderer #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
    .MAP_COLS(COLS)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .o_map_addr(map_addr), .i_map_data(map_data),
    .o_tile_addr(tile_addr), .i_tile_data(tile_data),
    .o_rgb(rgb), .o_hsync(hsync), .o_vsync(vsync), .o_frame_tick(frame_tick)
  );

  logic [2:0] map_mem  [0:4799];
  logic       tile_mem [0:383];

  always @(posedge clk) begin
    map_data  <= map_mem[map_addr];
    tile_data <= tile_mem[tile_addr];
  end

  int checks = 0;
  int failures = 0;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  // Reference model: everything derived from the linear pixel index p since reset release.
  function automatic int px_h(int p); return p % HT; endfunction
  function automatic int px_v(int p); return (p / HT) % VT; endfunction
  function automatic bit px_vis(int p); return (px_h(p) < HV) && (px_v(p) < VV); endfunction

  function automatic int pal(int c);
    if (c == 0) return 'h000;
    if (c <= 3) return 'h0F0;
    if (c == 4) return 'hFFF;
    if (c == 5) return 'hF00;
    return 'h000;
  endfunction

  function automatic int map_idx(int p);
    return px_vis(p) ? (px_v(p) / 8) * COLS + px_h(p) / 8 : 0;
  endfunction

  function automatic int exp_tile(int p);
    int c;
    c = int'(map_mem[map_idx(p)]);
    if (c >= 6) return 0;
    return c * 64 + (px_v(p) % 8) * 8 + (px_h(p) % 8);
  endfunction

  function automatic int exp_rgb(int p);
    int c;
    if (!px_vis(p)) return 0;
    c = int'(map_mem[map_idx(p)]);
    if (c >= 6) return 0;
    return tile_mem[exp_tile(p)] ? pal(c) : 0;
  endfunction

  task automatic check_reset_vals();
    chk("rst_map", 32'(map_addr), 0);
    chk("rst_tile", 32'(tile_addr), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_hs", 32'(hsync), 1);
    chk("rst_vs", 32'(vsync), 1);
    chk("rst_tick", 32'(frame_tick), 0);
  endtask

  task automatic check_cycle();
    if (n == 0) chk("map0", 32'(map_addr), 0);
    else        chk("map", 32'(map_addr), map_idx(n - 1));
    if (n == 0)      chk("tile0", 32'(tile_addr), 0);
    else if (n >= 3) chk("tile", 32'(tile_addr), exp_tile(n - 3));
    if (n < 5) begin
      chk("rgb_flush", 32'(rgb), 0);
      chk("hs_flush", 32'(hsync), 1);
      chk("vs_flush", 32'(vsync), 1);
    end else begin
      chk("rgb", 32'(rgb), exp_rgb(n - 5));
      chk("hs", 32'(hsync), (px_h(n - 5) >= HSS && px_h(n - 5) < HSE) ? 0 : 1);
      chk("vs", 32'(vsync), (px_v(n - 5) >= VSS && px_v(n - 5) < VSE) ? 0 : 1);
    end
    chk("tick", 32'(frame_tick), (px_h(n) == 0 && px_v(n) == VV) ? 1 : 0);
    // Directed points with hand-computed constants.
    if (n == 5)                 chk("px00_code4", 32'(rgb), 'hFFF);
    if (n == 11)                chk("code7_tile", 32'(tile_addr), 0);
    if (n == 13)                chk("code7_rgb", 32'(rgb), 0);
    if (n == 21)                chk("code2_rgb", 32'(rgb), 'h0F0);
    if (n == 29)                chk("code5_bit0", 32'(rgb), 0);
    if (n == 17 * HT + 13 + 1)  chk("addr_13_17", 32'(map_addr), 161);
    if (n == 17 * HT + 13 + 3)  chk("tile_13_17", 32'(tile_addr), 333);
    if (n == 641)               chk("map_h640", 32'(map_addr), 0);
    if (n == 645)               chk("rgb_h640", 32'(rgb), 0);
    if (n == 23 * HT + 639 + 1) chk("map_last", 32'(map_addr), 239);
    if (n == VV * HT)           chk("tick_pos", 32'(frame_tick), 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    check_cycle();
  endtask

  initial begin
    for (int i = 0; i < 4800; i++) map_mem[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 384; i++)  tile_mem[i] = 1'($urandom_range(0, 1));
    map_mem[0] = 3'd4;  tile_mem[256] = 1'b1;
    map_mem[1] = 3'd7;
    map_mem[2] = 3'd2;  tile_mem[128] = 1'b1;
    map_mem[3] = 3'd5;  tile_mem[320] = 1'b0;
    map_mem[161] = 3'd5;
    n = 0;

    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_reset_vals();
    end
    rst = 1'b0;
    n = 0;
    check_cycle();
    while (n < 10 * HT + 300) step();

    // Abort mid-frame at pixel (300,10).
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_vals();
    end
    rst = 1'b0;
    n = 0;
    check_cycle();
    while (n < HT * VT + VV * HT + 10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
